srff_bank: RTL
==============

SRFF_BANK -- requirements
Module: srff_bank

Interface
REQ-001 The block SHALL have parameter WIDE, default 18, meaning the number of independent set/clear channels (1..64).
REQ-002 The block SHALL have parameter MODE, default 0, meaning the conflict policy: 0 set-wins, 1 clear-wins, 2 hold, 3 toggle.
REQ-003 The block SHALL have parameter DLY, default 1, meaning the number of output register stages after the state register (0..4).
REQ-004 The block SHALL have parameter RST_VAL, default all-zero WIDE-bit vector, meaning the state value loaded on reset.
REQ-005 clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 rst  input  1  synchronous reset, active high.
REQ-007 preset_n  input  WIDE  per-channel set request, active low.
REQ-008 clear_n  input  WIDE  per-channel clear request, active low.
REQ-009 ack  input  WIDE  per-channel write-1-to-clear for rise_pend.
REQ-010 q  output  WIDE  delayed channel state.
REQ-011 qbar  output  WIDE  always the bitwise inverse of q.
REQ-012 rise_pend  output  WIDE  sticky flag: state went 0->1.
REQ-013 irq  output  1  OR of all rise_pend bits.
REQ-014 conflict_cnt  output  8  saturating count of cycles with any channel in conflict.

Function
REQ-015 Each channel SHALL hold internal state s[i], updated every clock from preset_n[i] and clear_n[i].
REQ-016 Both requests high: s[i] SHALL hold.
REQ-017 Only preset_n[i] low: s[i] SHALL become 1.
REQ-018 Only clear_n[i] low: s[i] SHALL become 0.
REQ-019 Both low (conflict): s[i] SHALL follow MODE -- set-wins 1, clear-wins 0, hold unchanged, toggle ~s[i].
REQ-020 q SHALL equal s delayed by DLY further clocks; with DLY=0 it SHALL equal s directly, so total request-to-q latency is DLY+1 clocks.
REQ-021 qbar SHALL equal ~q in every cycle, including during reset.
REQ-022 rise_pend[i] SHALL set the clock after s[i] changes 0->1, measured on s rather than q so it is independent of DLY.
REQ-023 rise_pend[i] SHALL clear the clock after ack[i]=1.
REQ-024 If ack[i] arrives in the same cycle as a new 0->1 transition of channel i, rise_pend[i] SHALL remain 1 (set wins).
REQ-025 irq SHALL be combinational from the rise_pend register.
REQ-026 conflict_cnt SHALL increment by 1 in each cycle where any channel has both requests low, regardless of MODE.
REQ-027 conflict_cnt SHALL saturate at 255 and never wrap.
REQ-028 Inputs SHALL be treated as already synchronous; there SHALL be no internal synchronisers.

Reset
REQ-029 On rst=1 at a clock edge, s and every delay stage SHALL load RST_VAL, so q=RST_VAL and qbar=~RST_VAL on the next cycle.
REQ-030 On rst=1 at a clock edge, rise_pend SHALL load 0, irq SHALL be 0 and conflict_cnt SHALL load 0.
REQ-031 rst SHALL override all requests and ack in the same cycle.
REQ-032 rst asserted mid-operation SHALL discard in-flight delay-stage contents.
REQ-033 The reset-load to RST_VAL SHALL NOT set rise_pend.

Structure
REQ-034 A shared package SHALL hold the MODE encoding constants (MODE_SET_WINS, MODE_CLR_WINS, MODE_HOLD, MODE_TOGGLE) and the DLY_MAX=4 constant.
REQ-035 Per-channel next-state logic SHALL be one sub-module, srff_cell, instanced WIDE times.
REQ-036 The delay pipeline, pending flags and counter SHALL live in srff_bank.
REQ-037 Illegal MODE or DLY values SHALL be rejected at elaboration.

Verification
REQ-038 Set/clear, WIDE=18, DLY=1, MODE=0: preset_n[1]=0 for one cycle -> q[1]=1 two clocks later, rise_pend[1]=1, irq=1; then clear_n[1]=0 -> q[1]=0 two clocks later.
REQ-039 MODE sweep: both requests low on channel 5 for 3 cycles from s=0 -> set-wins s=1, clear-wins s=0, hold s=0, toggle s=1,0,1; conflict_cnt=3 in every mode.
REQ-040 Ack collision: ack[3]=1 in the same cycle as a new rise on channel 3 -> rise_pend[3] stays 1; ack[3]=1 the next cycle -> rise_pend[3]=0 and irq=0.
REQ-041 Saturation: hold a conflict for 300 cycles -> conflict_cnt stops at 255.
REQ-042 Reset mid-flight: DLY=3, RST_VAL=18'h00001, rst pulsed while q changes propagate -> next cycle q=18'h00001, qbar=18'h3FFFE, rise_pend=0, conflict_cnt=0.
REQ-043 All four scenarios above SHALL be rerun with DLY=0 and DLY=4, and latency SHALL equal DLY+1.

Source files
------------

// File: rtl/srff_bank_pkg.sv
// Shared constants and helpers for the set/clear flip-flop bank.
package srff_bank_pkg;

    // Conflict policy when both set and clear are requested together.
    localparam int unsigned MODE_SET_WINS = 0;
    localparam int unsigned MODE_CLR_WINS = 1;
    localparam int unsigned MODE_HOLD     = 2;
    localparam int unsigned MODE_TOGGLE   = 3;

    // Deepest supported output delay pipeline.
    localparam int unsigned DLY_MAX = 4;

    // Counter ceiling; the conflict counter sticks here.
    localparam logic [7:0] CNT_MAX = 8'hFF;

    // Next state of one channel when both requests are active.
    function automatic logic conflict_next(input int unsigned mode, input logic s);
        logic r;
        case (mode)
            MODE_SET_WINS: r = 1'b1;
            MODE_CLR_WINS: r = 1'b0;
            MODE_TOGGLE:   r = ~s;
            default:       r = s;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/srff_cell.sv
// Next-state logic for a single set/clear channel with active-low requests.
module srff_cell
    import srff_bank_pkg::*;
#(
    parameter int unsigned MODE = MODE_SET_WINS
) (
    input  logic s,
    input  logic preset_n,
    input  logic clear_n,
    output logic s_next,
    output logic conflict
);

    // Decode the request pair; both low defers to the conflict policy.
    always_comb begin
        conflict = ~preset_n & ~clear_n;
        case ({preset_n, clear_n})
            2'b11:   s_next = s;
            2'b01:   s_next = 1'b1;
            2'b10:   s_next = 1'b0;
            default: s_next = conflict_next(MODE, s);
        endcase
    end

endmodule

// File: rtl/srff_bank.sv
// Bank of independent set/clear flip-flops with an output delay pipeline,
// sticky rising-edge flags and a saturating conflict counter.
module srff_bank
    import srff_bank_pkg::*;
#(
    parameter int unsigned      WIDE    = 18,
    parameter int unsigned      MODE    = 0,
    parameter int unsigned      DLY     = 1,
    parameter logic [WIDE-1:0]  RST_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [WIDE-1:0] preset_n,
    input  logic [WIDE-1:0] clear_n,
    input  logic [WIDE-1:0] ack,
    output logic [WIDE-1:0] q,
    output logic [WIDE-1:0] qbar,
    output logic [WIDE-1:0] rise_pend,
    output logic            irq,
    output logic [7:0]      conflict_cnt
);

    if (MODE > MODE_TOGGLE || DLY > DLY_MAX || WIDE == 0 || WIDE > 64) begin : g_param_err
        $error("srff_bank: illegal parameters WIDE=%0d MODE=%0d DLY=%0d", WIDE, MODE, DLY);
    end

    logic [WIDE-1:0] s_q;
    logic [WIDE-1:0] s_d;
    logic [WIDE-1:0] conflict;
    logic [WIDE-1:0] rise;
    logic [WIDE-1:0] rise_pend_q;
    logic [WIDE-1:0] rise_pend_d;
    logic [7:0]      cnt_q;
    logic [7:0]      cnt_d;
    logic            any_conflict;

    for (genvar i = 0; i < WIDE; i++) begin : g_cell
        srff_cell #(
            .MODE(MODE)
        ) u_cell (
            .s       (s_q[i]),
            .preset_n(preset_n[i]),
            .clear_n (clear_n[i]),
            .s_next  (s_d[i]),
            .conflict(conflict[i])
        );
    end

    // Channel state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q <= RST_VAL;
        end else begin
            s_q <= s_d;
        end
    end

    // Output delay pipeline; DLY=0 exposes the state register directly.
    if (DLY == 0) begin : g_nodly
        assign q = s_q;
    end else begin : g_dly
        logic [WIDE-1:0] pipe_q [DLY];

        // Shift the state down the pipeline; reset flushes every stage.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < DLY; k++) begin
                    pipe_q[k] <= RST_VAL;
                end
            end else begin
                pipe_q[0] <= s_q;
                for (int k = 1; k < DLY; k++) begin
                    pipe_q[k] <= pipe_q[k-1];
                end
            end
        end

        assign q = pipe_q[DLY-1];
    end

    assign qbar = ~q;

    // Rise detection is taken on the state update itself so it does not depend on DLY;
    // a new rise beats a same-cycle ack.
    always_comb begin
        rise         = s_d & ~s_q;
        rise_pend_d  = (rise_pend_q & ~ack) | rise;
        any_conflict = |conflict;
        cnt_d        = cnt_q;
        if (any_conflict && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Pending flags and conflict counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_pend_q <= '0;
            cnt_q       <= '0;
        end else begin
            rise_pend_q <= rise_pend_d;
            cnt_q       <= cnt_d;
        end
    end

    assign rise_pend    = rise_pend_q;
    assign irq          = |rise_pend_q;
    assign conflict_cnt = cnt_q;

endmodule
